control_unit: RTL
=================

CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 8'h00, meaning the program counter value loaded on reset.
REQ-002 SHALL have port clk  input  1  clock; all state changes on the rising edge.
REQ-003 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-004 SHALL have port imem_req  output  1  instruction byte fetch request.
REQ-005 SHALL have port imem_addr  output  8  fetch address, equal to pc.
REQ-006 SHALL have port imem_ack  input  1  fetch complete; imem_rdata valid this cycle.
REQ-007 SHALL have port imem_rdata  input  8  fetched byte.
REQ-008 SHALL have port dmem_req, dmem_ack  output/input  1 each  data memory handshake.
REQ-009 SHALL have port mem_op  output  2  MEM_OPS_T (MEM_NOP/MEM_READ/MEM_WRITE).
REQ-010 SHALL have port mem_addr  output  8  data address: op_b for LDM, op_a for STR/STD, else 0.
REQ-011 SHALL have ports op_a, op_b  output  8 each  latched operand bytes 1 and 2.
REQ-012 SHALL have ports alu_op  output  4  ALU_OPS_T; src_sel  output  2  DATA_SOURCE_T; flag_src  output  4  FLAG_SOURCE_T.
REQ-013 SHALL have ports reg_we, flag_we  output  1 each  register-file and flags write strobes.
REQ-014 SHALL have ports state  output  2  STATE_T; pc  output  8; halted  output  1; illegal  output  1.

Function
REQ-015 Each instruction SHALL be three bytes in order: opcode (OPCODES_T), op_a, op_b.
REQ-016 FETCH: imem_req=1 with imem_addr=pc until imem_ack; on ack, the byte is latched into slot byte_cnt, pc increments and byte_cnt advances; after the third ack, next state is DECODE.
REQ-017 pc SHALL wrap 8'hFF->8'h00, including within one instruction.
REQ-018 DECODE (1 cycle) SHALL register alu_op, src_sel, mem_op, flag_src per REQ-019..022; outputs hold through WRITEBACK.
REQ-019 LDM: MEM/MEM_READ/reg_we. LDR: REG/reg_we. LDD: VAL/reg_we. STR: REG/MEM_WRITE. STD: VAL/MEM_WRITE.
REQ-020 ADR/SBR/ANR/ORR/XOR: REG with ALU_ADD/SUB/AND/OR/XOR; ADD/SBD/AND/ORD/XOD: same ops with VAL; all assert reg_we and flag_we with flag_src=ALU.
REQ-021 CPR (REG) / CPD (VAL): ALU_CMP, flag_we only, no reg_we.
REQ-022 NOP: all controls idle (ALU_NOP, MEM_NOP, NONE); proceeds DECODE->EXECUTE->WRITEBACK->FETCH with no strobes.
REQ-023 EXECUTE: if mem_op!=MEM_NOP, dmem_req=1 until dmem_ack, then WRITEBACK; otherwise exactly 1 cycle.
REQ-024 WRITEBACK (1 cycle): reg_we and flag_we pulse high for exactly this cycle where REQ-019..021 specify; next state FETCH.
REQ-025 HALT decoded SHALL set halted=1 the next cycle, hold state=EXECUTE, drive no requests or strobes until reset.
REQ-026 imem_ack or dmem_ack arriving while not requested SHALL be ignored.
REQ-027 Minimum latency: 3 fetch cycles + DECODE + EXECUTE + WRITEBACK = 6 cycles per non-memory instruction.

Reset
REQ-028 On rst: state=FETCH, pc=RESET_PC, byte_cnt=0, op_a=op_b=0, alu_op=ALU_NOP, src_sel=VAL, mem_op=MEM_NOP, flag_src=NONE, all strobes/requests/halted/illegal=0.
REQ-029 rst mid-fetch or mid-memory-access SHALL drop imem_req/dmem_req in the following cycle and discard partial bytes.

Configuration
REQ-030 Macro ILLEGAL_TRAP_EN: when defined, opcode > HALT sets illegal=1 and halted=1 as in REQ-025; when undefined, such opcodes execute as NOP and illegal is tied 0.

Verification
REQ-031 Reset, imem_ack every cycle, bytes 02,03,5A (LDD r3,5A) -> WRITEBACK on cycle 6 with reg_we=1, src_sel=VAL, op_a=03, op_b=5A, pc=03.
REQ-032 LDM 01,20 with dmem_ack delayed 3 cycles -> dmem_req held 3 cycles, mem_addr=20, mem_op=MEM_READ, reg_we pulses once.
REQ-033 CPD 02,10 -> alu_op=ALU_CMP, flag_we=1, reg_we=0 in WRITEBACK.
REQ-034 RESET_PC=FE, three NOPs -> imem_addr sequence FE,FF,00,..., no strobes.
REQ-035 HALT then imem_ack pulses -> halted=1, imem_req stays 0; rst restores pc=RESET_PC.
REQ-036 Opcode 8'hFF: with ILLEGAL_TRAP_EN illegal=halted=1; without, treated as NOP and fetch continues.

Source files
------------

// File: rtl/control_unit.sv
// Multi-cycle control unit: fetches 3-byte instructions, decodes them and sequences
// memory and writeback strobes. Define ILLEGAL_TRAP_EN to trap opcodes above HALT.
module control_unit #(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  output logic       imem_req,
  output logic [7:0] imem_addr,
  input  logic       imem_ack,
  input  logic [7:0] imem_rdata,
  output logic       dmem_req,
  input  logic       dmem_ack,
  output logic [1:0] mem_op,
  output logic [7:0] mem_addr,
  output logic [7:0] op_a,
  output logic [7:0] op_b,
  output logic [3:0] alu_op,
  output logic [1:0] src_sel,
  output logic [3:0] flag_src,
  output logic       reg_we,
  output logic       flag_we,
  output logic [1:0] state,
  output logic [7:0] pc,
  output logic       halted,
  output logic       illegal
);

  // state     | meaning
  // FETCH     | request bytes at pc until three have been acknowledged
  // DECODE    | register control fields for the latched opcode
  // EXECUTE   | data memory handshake if needed; parks here once halted
  // WRITEBACK | pulse register/flag write strobes
  typedef enum logic [1:0] {ST_FETCH, ST_DECODE, ST_EXECUTE, ST_WRITEBACK} state_t;

  typedef enum logic [7:0] {
    OP_LDM = 8'h00, OP_LDR = 8'h01, OP_LDD = 8'h02, OP_STR = 8'h03, OP_STD = 8'h04,
    OP_ADR = 8'h05, OP_SBR = 8'h06, OP_ANR = 8'h07, OP_ORR = 8'h08, OP_XOR = 8'h09,
    OP_ADD = 8'h0A, OP_SBD = 8'h0B, OP_AND = 8'h0C, OP_ORD = 8'h0D, OP_XOD = 8'h0E,
    OP_CPR = 8'h0F, OP_CPD = 8'h10, OP_NOP = 8'h11, OP_HALT = 8'h12
  } opcode_t;

  typedef enum logic [3:0] {ALU_NOP, ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_CMP} alu_op_t;
  typedef enum logic [1:0] {SRC_REG, SRC_VAL, SRC_MEM} src_t;
  typedef enum logic [1:0] {MEM_NOP, MEM_READ, MEM_WRITE} mem_op_t;
  typedef enum logic [3:0] {FLAG_NONE, FLAG_ALU} flag_src_t;

  state_t    state_q, state_d;
  logic [7:0] pc_q, pc_d;
  logic [1:0] byte_cnt_q, byte_cnt_d;
  logic [7:0] opcode_q, opcode_d;
  logic [7:0] op_a_q, op_a_d;
  logic [7:0] op_b_q, op_b_d;
  alu_op_t   alu_op_q, alu_op_d;
  src_t      src_sel_q, src_sel_d;
  mem_op_t   mem_op_q, mem_op_d;
  logic [7:0] mem_addr_q, mem_addr_d;
  flag_src_t flag_src_q, flag_src_d;
  logic      rf_wr_q, rf_wr_d;
  logic      fl_wr_q, fl_wr_d;
  logic      halted_q, halted_d;
  logic      illegal_q, illegal_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_FETCH;
      pc_q       <= RESET_PC;
      byte_cnt_q <= 2'd0;
      opcode_q   <= 8'h00;
      op_a_q     <= 8'h00;
      op_b_q     <= 8'h00;
      alu_op_q   <= ALU_NOP;
      src_sel_q  <= SRC_VAL;
      mem_op_q   <= MEM_NOP;
      mem_addr_q <= 8'h00;
      flag_src_q <= FLAG_NONE;
      rf_wr_q    <= 1'b0;
      fl_wr_q    <= 1'b0;
      halted_q   <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      byte_cnt_q <= byte_cnt_d;
      opcode_q   <= opcode_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      alu_op_q   <= alu_op_d;
      src_sel_q  <= src_sel_d;
      mem_op_q   <= mem_op_d;
      mem_addr_q <= mem_addr_d;
      flag_src_q <= flag_src_d;
      rf_wr_q    <= rf_wr_d;
      fl_wr_q    <= fl_wr_d;
      halted_q   <= halted_d;
      illegal_q  <= illegal_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    byte_cnt_d = byte_cnt_q;
    opcode_d   = opcode_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    alu_op_d   = alu_op_q;
    src_sel_d  = src_sel_q;
    mem_op_d   = mem_op_q;
    mem_addr_d = mem_addr_q;
    flag_src_d = flag_src_q;
    rf_wr_d    = rf_wr_q;
    fl_wr_d    = fl_wr_q;
    halted_d   = halted_q;
    illegal_d  = illegal_q;

    case (state_q)
      ST_FETCH: begin
        if (imem_ack) begin
          case (byte_cnt_q)
            2'd0:    opcode_d = imem_rdata;
            2'd1:    op_a_d   = imem_rdata;
            default: op_b_d   = imem_rdata;
          endcase
          pc_d = pc_q + 8'd1;
          if (byte_cnt_q == 2'd2) begin
            byte_cnt_d = 2'd0;
            state_d    = ST_DECODE;
          end else begin
            byte_cnt_d = byte_cnt_q + 2'd1;
          end
        end
      end

      ST_DECODE: begin
        alu_op_d   = ALU_NOP;
        src_sel_d  = SRC_VAL;
        mem_op_d   = MEM_NOP;
        mem_addr_d = 8'h00;
        flag_src_d = FLAG_NONE;
        rf_wr_d    = 1'b0;
        fl_wr_d    = 1'b0;
        state_d    = ST_EXECUTE;

        case (opcode_q)
          OP_LDM: begin
            src_sel_d  = SRC_MEM;
            mem_op_d   = MEM_READ;
            mem_addr_d = op_b_q;
            rf_wr_d    = 1'b1;
          end
          OP_LDR: begin
            src_sel_d = SRC_REG;
            rf_wr_d   = 1'b1;
          end
          OP_LDD: rf_wr_d = 1'b1;
          OP_STR: begin
            src_sel_d  = SRC_REG;
            mem_op_d   = MEM_WRITE;
            mem_addr_d = op_a_q;
          end
          OP_STD: begin
            mem_op_d   = MEM_WRITE;
            mem_addr_d = op_a_q;
          end
          OP_ADR, OP_SBR, OP_ANR, OP_ORR, OP_XOR, OP_CPR: src_sel_d = SRC_REG;
          OP_ADD, OP_SBD, OP_AND, OP_ORD, OP_XOD, OP_CPD: src_sel_d = SRC_VAL;
          OP_NOP: ;
          OP_HALT: halted_d = 1'b1;
          default: begin
`ifdef ILLEGAL_TRAP_EN
            halted_d  = 1'b1;
            illegal_d = 1'b1;
`endif
          end
        endcase

        case (opcode_q)
          OP_ADR, OP_ADD: alu_op_d = ALU_ADD;
          OP_SBR, OP_SBD: alu_op_d = ALU_SUB;
          OP_ANR, OP_AND: alu_op_d = ALU_AND;
          OP_ORR, OP_ORD: alu_op_d = ALU_OR;
          OP_XOR, OP_XOD: alu_op_d = ALU_XOR;
          OP_CPR, OP_CPD: alu_op_d = ALU_CMP;
          default:        alu_op_d = ALU_NOP;
        endcase

        // Every ALU op updates flags; compares leave the register file alone.
        if (alu_op_d != ALU_NOP) begin
          flag_src_d = FLAG_ALU;
          fl_wr_d    = 1'b1;
          rf_wr_d    = (alu_op_d != ALU_CMP);
        end
      end

      ST_EXECUTE: begin
        if (!halted_q && ((mem_op_q == MEM_NOP) || dmem_ack))
          state_d = ST_WRITEBACK;
      end

      ST_WRITEBACK: begin
        state_d    = ST_FETCH;
        alu_op_d   = ALU_NOP;
        src_sel_d  = SRC_VAL;
        mem_op_d   = MEM_NOP;
        mem_addr_d = 8'h00;
        flag_src_d = FLAG_NONE;
        rf_wr_d    = 1'b0;
        fl_wr_d    = 1'b0;
      end

      default: state_d = ST_FETCH;
    endcase
  end

  // Requests are masked while rst is high so a reset mid-transfer never leaves one open.
  assign imem_req  = (state_q == ST_FETCH) && !rst;
  assign dmem_req  = (state_q == ST_EXECUTE) && (mem_op_q != MEM_NOP) && !halted_q && !rst;
  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign op_a      = op_a_q;
  assign op_b      = op_b_q;
  assign alu_op    = alu_op_q;
  assign src_sel   = src_sel_q;
  assign mem_op    = mem_op_q;
  assign mem_addr  = mem_addr_q;
  assign flag_src  = flag_src_q;
  assign reg_we    = (state_q == ST_WRITEBACK) && rf_wr_q;
  assign flag_we   = (state_q == ST_WRITEBACK) && fl_wr_q;
  assign state     = state_q;
  assign halted    = halted_q;
`ifdef ILLEGAL_TRAP_EN
  assign illegal   = illegal_q;
`else
  assign illegal   = 1'b0;
  logic unused_illegal;
  assign unused_illegal = illegal_q;
`endif

endmodule
